// File: rtl/uart_frame_loader.sv
// Parses framed packets from the UART byte stream (sync, address, length, payload, XOR checksum)
// and writes the payload as 16-bit words to the frame SRAM over a request/acknowledge port.
module uart_frame_loader #(
   parameter int unsigned ADDR_WIDTH     = 18,
   parameter logic [7:0]  SYNC0          = 8'hAA,
   parameter logic [7:0]  SYNC1          = 8'h55,
   parameter int unsigned TIMEOUT_CYCLES = 104160
) (
   input  logic                  i_clk_sys,
   input  logic                  i_rst,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_sram_wr_req,
   output logic [ADDR_WIDTH-1:0] o_sram_addr,
   output logic [15:0]           o_sram_data,
   input  logic                  i_sram_wr_ack,
   output logic                  o_frame_ok,
   output logic                  o_frame_err,
   output logic [1:0]            o_err_code,
   output logic                  o_busy,
   output logic [2:0]            o_state
);

   localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_CHECKSUM = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_ADDR    = 3'd2,
      ST_LEN     = 3'd3,
      ST_DATA_HI = 3'd4,
      ST_DATA_LO = 3'd5,
      ST_CHK     = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            chk_q, chk_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic                  wr_req_q, wr_req_d;
   logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]           sram_data_q, sram_data_d;
   logic                  frame_ok_q, frame_ok_d;
   logic                  frame_err_q, frame_err_d;
   logic [1:0]            err_code_q, err_code_d;
   logic                  busy_q, busy_d;
   logic [15:0]           len_c;

   assign len_c = {cnt_q[7:0], i_rx_data};

   // Next-state, datapath and output computation
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      chk_d       = chk_q;
      gap_d       = gap_q;
      wr_req_d    = wr_req_q;
      sram_addr_d = sram_addr_q;
      sram_data_d = sram_data_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;

      if (wr_req_q && i_sram_wr_ack) begin
         wr_req_d = 1'b0;
      end

      if (i_rx_done) begin
         gap_d = '0;
         unique case (state_q)
            ST_IDLE: begin
               if (i_rx_data == SYNC0) state_d = ST_SYNC;
            end
            ST_SYNC: begin
               if (i_rx_data == SYNC1) begin
                  state_d = ST_ADDR;
                  chk_d   = 8'h00;
                  idx_d   = 2'd0;
                  addr_d  = '0;
               end else if (i_rx_data != SYNC0) begin
                  state_d = ST_IDLE;
               end
            end
            ST_ADDR: begin
               chk_d  = chk_q ^ i_rx_data;
               addr_d = ADDR_WIDTH'({addr_q, i_rx_data});
               if (idx_q == 2'd2) begin
                  idx_d   = 2'd0;
                  cnt_d   = 16'h0000;
                  state_d = ST_LEN;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            ST_LEN: begin
               chk_d = chk_q ^ i_rx_data;
               cnt_d = len_c;
               if (idx_q == 2'd0) begin
                  idx_d = 2'd1;
               end else begin
                  idx_d   = 2'd0;
                  state_d = (len_c == 16'h0000) ? ST_CHK : ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               chk_d   = chk_q ^ i_rx_data;
               hi_d    = i_rx_data;
               state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               chk_d = chk_q ^ i_rx_data;
               // A word with the previous write still outstanding is dropped and aborts the frame
               if (wr_req_q && !i_sram_wr_ack) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_OVERFLOW;
                  state_d     = ST_IDLE;
               end else begin
                  wr_req_d    = 1'b1;
                  sram_addr_d = addr_q;
                  sram_data_d = {hi_q, i_rx_data};
                  addr_d      = addr_q + ADDR_WIDTH'(1);
                  cnt_d       = cnt_q - 16'd1;
                  state_d     = (cnt_q == 16'd1) ? ST_CHK : ST_DATA_HI;
               end
            end
            ST_CHK: begin
               if (i_rx_data == chk_q) begin
                  frame_ok_d = 1'b1;
                  err_code_d = ERR_NONE;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHECKSUM;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (gap_q == GAP_LAST) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
            gap_d       = '0;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end else begin
         gap_d = '0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         addr_q      <= '0;
         cnt_q       <= 16'h0000;
         hi_q        <= 8'h00;
         chk_q       <= 8'h00;
         gap_q       <= '0;
         wr_req_q    <= 1'b0;
         sram_addr_q <= '0;
         sram_data_q <= 16'h0000;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         chk_q       <= chk_d;
         gap_q       <= gap_d;
         wr_req_q    <= wr_req_d;
         sram_addr_q <= sram_addr_d;
         sram_data_q <= sram_data_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         busy_q      <= busy_d;
      end
   end

   assign o_sram_wr_req = wr_req_q;
   assign o_sram_addr   = sram_addr_q;
   assign o_sram_data   = sram_data_q;
   assign o_frame_ok    = frame_ok_q;
   assign o_frame_err   = frame_err_q;
   assign o_err_code    = err_code_q;
   assign o_busy        = busy_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: a frame-level model builds byte streams plus expected writes/end events,
// a per-cycle monitor compares the SRAM port and pulses against them, and directed checks pin timing.
module tb_uart_frame_loader;

   localparam int unsigned T  = 40;
   localparam int unsigned AW = 18;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_done;
   logic          man_ack;
   logic          auto_ack;
   wire           ack_w = man_ack | auto_ack;
   logic          o_sram_wr_req;
   logic [AW-1:0] o_sram_addr;
   logic [15:0]   o_sram_data;
   logic          o_frame_ok;
   logic          o_frame_err;
   logic [1:0]    o_err_code;
   logic          o_busy;
   logic [2:0]    o_state;

   logic          auto_en = 1'b0;
   int            ack_lat = 0;

   wr_t           exp_wr_q[$];
   int            exp_ev_q[$];
   logic [7:0]    byte_q[$];
   logic [15:0]   words[$];
   int            total = 0;
   int            bad   = 0;

   uart_frame_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
      .i_clk_sys    (clk),
      .i_rst        (rst),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .o_sram_wr_req(o_sram_wr_req),
      .o_sram_addr  (o_sram_addr),
      .o_sram_data  (o_sram_data),
      .i_sram_wr_ack(ack_w),
      .o_frame_ok   (o_frame_ok),
      .o_frame_err  (o_frame_err),
      .o_err_code   (o_err_code),
      .o_busy       (o_busy),
      .o_state      (o_state)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endfunction

   // Frame model: byte stream from address + words, checksum = XOR of address..payload bytes
   function automatic void make_frame(input logic [23:0] a, input logic [7:0] chk_mask);
      logic [7:0]  chk = 8'h00;
      logic [15:0] n   = 16'(words.size());
      byte_q.delete();
      byte_q.push_back(8'hAA);
      byte_q.push_back(8'h55);
      byte_q.push_back(a[23:16]);
      byte_q.push_back(a[15:8]);
      byte_q.push_back(a[7:0]);
      byte_q.push_back(n[15:8]);
      byte_q.push_back(n[7:0]);
      for (int i = 0; i < words.size(); i++) begin
         byte_q.push_back(words[i][15:8]);
         byte_q.push_back(words[i][7:0]);
         exp_wr_q.push_back('{addr: AW'((int'(a) + i) % (1 << AW)), data: words[i]});
      end
      for (int i = 2; i < byte_q.size(); i++) chk ^= byte_q[i];
      byte_q.push_back(chk ^ chk_mask);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int edges = 1);
      repeat (edges) @(posedge clk);
      #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic send_frame(input int upto);
      for (int i = 0; i < upto; i++) send_byte(byte_q[i]);
   endtask

   // Acknowledge responder with programmable latency
   initial begin
      int ack_wait = 0;
      auto_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         auto_ack = 1'b0;
         if (auto_en && o_sram_wr_req && !rst) begin
            if (ack_wait >= ack_lat) begin
               auto_ack = 1'b1;
               ack_wait = 0;
            end else begin
               ack_wait++;
            end
         end else begin
            ack_wait = 0;
         end
      end
   end

   // Per-cycle monitor against the model queues
   initial begin
      logic prev_req   = 1'b0;
      logic prev_acc   = 1'b0;
      logic prev_pulse = 1'b0;
      wr_t  held       = '0;
      wr_t  w;
      int   ev;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req   = 1'b0;
            prev_acc   = 1'b0;
            prev_pulse = 1'b0;
         end else begin
            check("busy_vs_state", 32'(o_busy), 32'(o_state != 3'd0));
            if (o_sram_wr_req) begin
               if (!prev_req || prev_acc) begin
                  total++;
                  if (exp_wr_q.size() == 0) begin
                     bad++;
                     $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required none", o_sram_addr, o_sram_data);
                  end else begin
                     w = exp_wr_q.pop_front();
                     if (o_sram_addr !== w.addr || o_sram_data !== w.data) begin
                        bad++;
                        $display("FAIL write: actual addr=0x%0h data=0x%0h required addr=0x%0h data=0x%0h",
                                 o_sram_addr, o_sram_data, w.addr, w.data);
                     end
                  end
                  held = '{addr: o_sram_addr, data: o_sram_data};
               end else begin
                  check("write_hold_addr", 32'(o_sram_addr), 32'(held.addr));
                  check("write_hold_data", 32'(o_sram_data), 32'(held.data));
               end
            end
            if (o_frame_ok || o_frame_err) begin
               check("pulse_width", 32'(prev_pulse), 32'd0);
               total++;
               if (exp_ev_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_pulse: actual ok=%0b err=%0b required none", o_frame_ok, o_frame_err);
               end else begin
                  ev = exp_ev_q.pop_front();
                  if ({o_frame_ok, o_frame_err} !== ((ev == 0) ? 2'b10 : 2'b01) || 32'(o_err_code) !== 32'(ev)) begin
                     bad++;
                     $display("FAIL frame_end: actual ok=%0b err=%0b code=%0d required code=%0d",
                              o_frame_ok, o_frame_err, o_err_code, ev);
                  end
               end
            end
            prev_pulse = o_frame_ok | o_frame_err;
            prev_req   = o_sram_wr_req;
            prev_acc   = o_sram_wr_req & ack_w;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int k;
      rst     = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      man_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req",   32'(o_sram_wr_req), 32'd0);
      check("rst_addr",  32'(o_sram_addr),   32'd0);
      check("rst_data",  32'(o_sram_data),   32'd0);
      check("rst_ok",    32'(o_frame_ok),    32'd0);
      check("rst_err",   32'(o_frame_err),   32'd0);
      check("rst_code",  32'(o_err_code),    32'd0);
      check("rst_busy",  32'(o_busy),        32'd0);
      check("rst_state", 32'(o_state),       32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Good frame, ack in the request's first cycle
      auto_en = 1'b1;
      ack_lat = 0;
      words = '{16'h1234, 16'hABCD};
      make_frame(24'h000100, 8'h00);
      check("model_chk_good", 32'(byte_q[11]), 32'h43);
      check("model_wr0_addr", 32'(exp_wr_q[0].addr), 32'h00100);
      check("model_wr1_addr", 32'(exp_wr_q[1].addr), 32'h00101);
      exp_ev_q.push_back(0);
      for (int i = 0; i < 12; i++) begin
         send_byte(byte_q[i]);
         if (i == 8) begin
            check("good_req_latency", 32'(o_sram_wr_req), 32'd1);
            check("good_req_addr",    32'(o_sram_addr),   32'h00100);
            check("good_req_data",    32'(o_sram_data),   32'h1234);
         end
      end
      check("good_ok",   32'(o_frame_ok), 32'd1);
      check("good_code", 32'(o_err_code), 32'd0);
      @(posedge clk);
      #1;
      check("good_ok_drop", 32'(o_frame_ok), 32'd0);

      // Bad checksum
      ack_lat = 1;
      words = '{16'h1234, 16'hABCD};
      make_frame(24'h000100, 8'h07);
      check("model_chk_bad", 32'(byte_q[11]), 32'h44);
      exp_ev_q.push_back(1);
      send_frame(byte_q.size());
      check("badchk_err",  32'(o_frame_err), 32'd1);
      check("badchk_code", 32'(o_err_code),  32'd1);

      // Stray ack while idle, then leading garbage
      @(posedge clk);
      #1;
      man_ack = 1'b1;
      @(posedge clk);
      #1;
      man_ack = 1'b0;
      check("stray_ack_req", 32'(o_sram_wr_req), 32'd0);
      send_byte(8'h13);
      send_byte(8'hAA);
      send_byte(8'h77);
      check("garbage_busy", 32'(o_busy),      32'd0);
      check("garbage_err",  32'(o_frame_err), 32'd0);
      check("garbage_code", 32'(o_err_code),  32'd1);

      // Resync (AA AA 55) and zero length
      words.delete();
      make_frame(24'h000000, 8'h00);
      check("model_zero_len", 32'(byte_q.size()), 32'd8);
      exp_ev_q.push_back(0);
      send_byte(8'hAA);
      send_frame(byte_q.size());
      check("zero_ok",   32'(o_frame_ok), 32'd1);
      check("zero_code", 32'(o_err_code), 32'd0);

      // Address wrap
      ack_lat = 2;
      words = '{16'h5A5A, 16'h0F0F};
      make_frame(24'h03FFFF, 8'h00);
      check("model_wrap0", 32'(exp_wr_q[$-1].addr), 32'h3FFFF);
      check("model_wrap1", 32'(exp_wr_q[$].addr),   32'h00000);
      exp_ev_q.push_back(0);
      send_frame(byte_q.size());
      check("wrap_ok", 32'(o_frame_ok), 32'd1);

      // Byte arriving on the timeout cycle wins
      ack_lat = 0;
      words = '{16'h1234, 16'hABCD};
      make_frame(24'h000100, 8'h00);
      exp_ev_q.push_back(0);
      send_byte(byte_q[0]);
      send_byte(byte_q[1]);
      send_byte(byte_q[2], T - 1);
      check("race_no_err", 32'(o_frame_err), 32'd0);
      check("race_busy",   32'(o_busy),      32'd1);
      for (int i = 3; i < byte_q.size(); i++) send_byte(byte_q[i]);
      check("race_ok", 32'(o_frame_ok), 32'd1);

      // Timeout after the first LEN byte
      exp_ev_q.push_back(2);
      send_byte(8'hAA);
      send_byte(8'h55);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      k = 0;
      while (!o_frame_err && k < 3 * T) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("timeout_cycles", 32'(k),          32'(T));
      check("timeout_code",   32'(o_err_code), 32'd2);
      check("timeout_state",  32'(o_state),    32'd0);

      // Overflow with ack held low
      auto_en = 1'b0;
      words = '{16'h1122, 16'h3344};
      make_frame(24'h000010, 8'h00);
      void'(exp_wr_q.pop_back());
      exp_ev_q.push_back(3);
      send_frame(9);
      check("ovf_req1", 32'(o_sram_wr_req), 32'd1);
      send_byte(byte_q[9]);
      send_byte(byte_q[10]);
      check("ovf_err",  32'(o_frame_err),   32'd1);
      check("ovf_code", 32'(o_err_code),    32'd3);
      check("ovf_busy", 32'(o_busy),        32'd0);
      check("ovf_req",  32'(o_sram_wr_req), 32'd1);
      check("ovf_addr", 32'(o_sram_addr),   32'h00010);
      check("ovf_data", 32'(o_sram_data),   32'h1122);
      repeat (2) @(posedge clk);
      #1;
      check("ovf_req_hold", 32'(o_sram_wr_req), 32'd1);
      man_ack = 1'b1;
      @(posedge clk);
      #1;
      man_ack = 1'b0;
      check("late_ack_drop", 32'(o_sram_wr_req), 32'd0);

      // Reset during a pending write
      words = '{16'hBEEF};
      make_frame(24'h000020, 8'h00);
      send_frame(9);
      check("prerst_req", 32'(o_sram_wr_req), 32'd1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_req",   32'(o_sram_wr_req), 32'd0);
      check("rst_mid_addr",  32'(o_sram_addr),   32'd0);
      check("rst_mid_data",  32'(o_sram_data),   32'd0);
      check("rst_mid_busy",  32'(o_busy),        32'd0);
      check("rst_mid_state", 32'(o_state),       32'd0);
      check("rst_mid_code",  32'(o_err_code),    32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Recovery frame
      auto_en = 1'b1;
      ack_lat = 1;
      words = '{16'hCAFE};
      make_frame(24'h000200, 8'h00);
      exp_ev_q.push_back(0);
      send_frame(byte_q.size());
      check("recover_ok", 32'(o_frame_ok), 32'd1);

      repeat (10) @(posedge clk);
      #1;
      check("writes_left", 32'(exp_wr_q.size()), 32'd0);
      check("events_left", 32'(exp_ev_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
